// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared widths and tag layout for the two-port SDRAM arbiter
package memarb_pkg;
   localparam int MEMADDR_W = 23;
   localparam int MEMLEN_W  = 2;
   localparam int MEMDATA_W = 32;

   typedef struct packed {
      logic                port;
      logic [MEMLEN_W-1:0] len;
   } tag_t;
endpackage

// File: rtl/memarb_if.sv
// rtl/memarb_if.sv - memaddr/memlen/memreq/memready/memack request-and-beat bundle
interface memarb_if;
   import memarb_pkg::*;

   logic [MEMADDR_W-1:0] memaddr;
   logic [MEMLEN_W-1:0]  memlen;
   logic [MEMDATA_W-1:0] memwdata;
   logic                 memreq;
   logic                 memwr;
   logic                 memready;
   logic                 memack;
   logic [MEMDATA_W-1:0] memrdata;

   modport master (output memaddr, memlen, memwdata, memreq, memwr,
                   input  memready, memack, memrdata);
   modport slave  (input  memaddr, memlen, memwdata, memreq, memwr,
                   output memready, memack, memrdata);
endinterface

// File: rtl/memarb_tagfifo.sv
// rtl/memarb_tagfifo.sv - single-clock FIFO of {port,len} tags for outstanding bursts
module memarb_tagfifo
   import memarb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_data,
   input  logic pop,
   output tag_t pop_data,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   tag_t          mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + AW'(1);
         end
         if (pop)
            rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
endmodule

// File: rtl/memarb.sv
// rtl/memarb.sv - round-robin arbiter of capture (p0) and scan-out (p1) onto one SDRAM port
// MEMARB_PRIO_EN: p1 gets strict priority instead of round-robin.
module memarb
   import memarb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   memarb_if.slave  p0,
   memarb_if.slave  p1,
   memarb_if.master mem,
   output logic     err
);
   logic                g_arb;
   logic                g;
   logic                lock;
   logic                lock_g;
   logic                accept;
   logic                ack_ok;
   logic                pop;
   logic                tag_full;
   logic                tag_empty;
   logic [MEMLEN_W-1:0] beat;
   tag_t                head;
   tag_t                push_tag;

`ifdef MEMARB_PRIO_EN
   assign g_arb = p1.memreq;
`else
   logic rr;
   assign g_arb = (p0.memreq & p1.memreq) ? rr : p1.memreq;
`endif

   // A stalled downstream request keeps its owner so address/len cannot change under it.
   assign g = lock ? lock_g : g_arb;

   assign mem.memaddr = g ? p1.memaddr : p0.memaddr;
   assign mem.memlen  = g ? p1.memlen  : p0.memlen;
   assign mem.memwr   = g ? p1.memwr   : p0.memwr;
   assign mem.memreq  = (g ? p1.memreq : p0.memreq) & ~tag_full;

   assign accept      = mem.memreq & mem.memready;
   assign p0.memready = accept & ~g;
   assign p1.memready = accept & g;

   assign ack_ok      = mem.memack & ~tag_empty;
   assign p0.memack   = ack_ok & ~head.port;
   assign p1.memack   = ack_ok & head.port;
   assign p0.memrdata = mem.memrdata;
   assign p1.memrdata = mem.memrdata;

   // Write data follows the burst in flight; with nothing outstanding it follows the grant.
   assign mem.memwdata = tag_empty ? (g ? p1.memwdata : p0.memwdata)
                                   : (head.port ? p1.memwdata : p0.memwdata);

   assign pop      = ack_ok & (beat == head.len);
   assign push_tag = '{port: g, len: mem.memlen};

   memarb_tagfifo #(.DEPTH(DEPTH)) u_tagfifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (push_tag),
      .pop       (pop),
      .pop_data  (head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         lock   <= 1'b0;
         lock_g <= 1'b0;
         beat   <= '0;
         err    <= 1'b0;
`ifndef MEMARB_PRIO_EN
         rr     <= 1'b0;
`endif
      end else begin
         lock   <= mem.memreq & ~mem.memready;
         lock_g <= g;
`ifndef MEMARB_PRIO_EN
         if (accept)
            rr <= ~g;
`endif
         if (ack_ok)
            beat <= pop ? '0 : beat + MEMLEN_W'(1);
         if (mem.memack & tag_empty)
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_memarb.sv
// tb/tb_memarb.sv - scoreboard bench for memarb: grants and beats checked by a negedge monitor
module tb_memarb;
   import memarb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic err;

   memarb_if p0 ();
   memarb_if p1 ();
   memarb_if mem ();

   memarb #(.DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .p0  (p0),
      .p1  (p1),
      .mem (mem),
      .err (err)
   );

   always #5 clk = ~clk;

   typedef struct { logic port; logic [22:0] addr; } gexp_t;
   typedef struct { logic port; logic [31:0] data; } aexp_t;

   gexp_t gq[$];
   aexp_t aq[$];
   gexp_t ge;
   aexp_t ae;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (p0.memready | p1.memready) begin
            if (p0.memready & p1.memready) begin
               checks++; errors++;
               $display("FAIL grant_exclusive: both memready high");
            end else if (gq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_grant: port %0d addr %h with none expected", p1.memready, mem.memaddr);
            end else begin
               ge = gq.pop_front();
               chk("grant_port", {31'd0, p1.memready}, {31'd0, ge.port});
               chk("grant_addr", {9'd0, mem.memaddr}, {9'd0, ge.addr});
            end
         end
         if (p0.memack | p1.memack) begin
            if (p0.memack & p1.memack) begin
               checks++; errors++;
               $display("FAIL ack_exclusive: both memack high");
            end else if (aq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack: port %0d with none expected", p1.memack);
            end else begin
               ae = aq.pop_front();
               chk("ack_port", {31'd0, p1.memack}, {31'd0, ae.port});
               chk("ack_data", p1.memack ? p1.memrdata : p0.memrdata, ae.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp2 [4];
      logic post_rst_port;
`ifdef MEMARB_PRIO_EN
      exp2 = '{1'b1, 1'b1, 1'b1, 1'b1};
      post_rst_port = 1'b1;
`else
      exp2 = '{1'b0, 1'b1, 1'b0, 1'b1};
      post_rst_port = 1'b0;
`endif
      p0.memaddr = '0; p0.memlen = '0; p0.memwdata = '0; p0.memreq = 0; p0.memwr = 0;
      p1.memaddr = '0; p1.memlen = '0; p1.memwdata = '0; p1.memreq = 0; p1.memwr = 0;
      mem.memready = 0; mem.memack = 0; mem.memrdata = '0;

      // reset state
      step(); step();
      @(negedge clk);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_memreq", {31'd0, mem.memreq}, 32'd0);
      chk("rst_p0_memready", {31'd0, p0.memready}, 32'd0);
      chk("rst_tag_empty", {31'd0, dut.tag_empty}, 32'd1);
      chk("rst_beat", {30'd0, dut.beat}, 32'd0);
      step();
      rst = 1;

      // p1 alone, 4-beat read burst
      p1.memaddr = 23'h0; p1.memlen = 2'd3; p1.memreq = 1; mem.memready = 1;
      gq.push_back('{port: 1'b1, addr: 23'h0});
      @(negedge clk);
      chk("t1_memreq", {31'd0, mem.memreq}, 32'd1);
      step();
      p1.memreq = 0; mem.memready = 0;
      for (int i = 0; i < 4; i++) begin
         mem.memack = 1; mem.memrdata = 32'hA000_0000 + i;
         aq.push_back('{port: 1'b1, data: 32'hA000_0000 + i});
         @(negedge clk);
         chk("t1_p0_memack_low", {31'd0, p0.memack}, 32'd0);
         step();
      end
      mem.memack = 0;
      @(negedge clk);
      chk("t1_fifo_empty", {31'd0, dut.tag_empty}, 32'd1);
      step();

      // both ports request every cycle
      p0.memaddr = 23'h100; p0.memlen = 2'd0; p0.memwdata = 32'h1111_1111;
      p1.memaddr = 23'h200; p1.memlen = 2'd0; p1.memwdata = 32'h2222_2222;
      p0.memreq = 1; p1.memreq = 1; mem.memready = 1;
      for (int i = 0; i < 4; i++) begin
         gq.push_back('{port: exp2[i], addr: exp2[i] ? 23'h200 : 23'h100});
         step();
      end
      p0.memreq = 0; p1.memreq = 0; mem.memready = 0;
      for (int i = 0; i < 4; i++) begin
         mem.memack = 1; mem.memrdata = 32'hB000_0000 + i;
         aq.push_back('{port: exp2[i], data: 32'hB000_0000 + i});
         @(negedge clk);
         chk("t2_wdata", mem.memwdata, exp2[i] ? 32'h2222_2222 : 32'h1111_1111);
         step();
      end
      mem.memack = 0;

      // lock: p0 stalled by memready low while p1 rises
      p0.memaddr = 23'h2F0; p0.memreq = 1; mem.memready = 1;
      gq.push_back('{port: 1'b0, addr: 23'h2F0});
      step();
      p0.memaddr = 23'h300; mem.memready = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            p1.memaddr = 23'h400; p1.memreq = 1;
         end
         @(negedge clk);
         chk("t3_hold_addr", {9'd0, mem.memaddr}, 32'h300);
         step();
      end
      mem.memready = 1;
      gq.push_back('{port: 1'b0, addr: 23'h300});
      step();
      p0.memreq = 0;
      gq.push_back('{port: 1'b1, addr: 23'h400});
      step();
      p1.memreq = 0; mem.memready = 0;
      for (int i = 0; i < 3; i++) begin
         mem.memack = 1; mem.memrdata = 32'hC000_0000 + i;
         aq.push_back('{port: (i == 2), data: 32'hC000_0000 + i});
         step();
      end
      mem.memack = 0;

      // fill all 8 tags, 9th request blocked, one pop re-enables
      p0.memaddr = 23'h500; p0.memreq = 1; mem.memready = 1;
      for (int i = 0; i < 8; i++) begin
         gq.push_back('{port: 1'b0, addr: 23'h500});
         step();
      end
      @(negedge clk);
      chk("t4_full_memreq", {31'd0, mem.memreq}, 32'd0);
      chk("t4_full_memready", {31'd0, p0.memready}, 32'd0);
      step();
      mem.memack = 1; mem.memrdata = 32'hD000_0000;
      aq.push_back('{port: 1'b0, data: 32'hD000_0000});
      @(negedge clk);
      chk("t4_pop_cycle_memreq", {31'd0, mem.memreq}, 32'd0);
      step();
      mem.memack = 0;
      gq.push_back('{port: 1'b0, addr: 23'h500});
      @(negedge clk);
      chk("t4_reenable", {31'd0, mem.memreq}, 32'd1);
      step();
      p0.memreq = 0; mem.memready = 0;
      for (int i = 0; i < 8; i++) begin
         mem.memack = 1; mem.memrdata = 32'hD100_0000 + i;
         aq.push_back('{port: 1'b0, data: 32'hD100_0000 + i});
         step();
      end
      mem.memack = 0;

      // stray ack with nothing outstanding
      mem.memack = 1; mem.memrdata = 32'hE000_0000;
      @(negedge clk);
      chk("t5_no_pack", {31'd0, p0.memack | p1.memack}, 32'd0);
      step();
      mem.memack = 0;
      @(negedge clk);
      chk("t5_err_set", {31'd0, err}, 32'd1);
      step();
      @(negedge clk);
      chk("t5_err_sticky", {31'd0, err}, 32'd1);
      step();
      rst = 0;
      step();
      rst = 1;
      @(negedge clk);
      chk("t5_err_cleared", {31'd0, err}, 32'd0);
      step();

      // reset mid-burst drops the tag; the next beat is stray
      p1.memaddr = 23'h600; p1.memlen = 2'd3; p1.memreq = 1; mem.memready = 1;
      gq.push_back('{port: 1'b1, addr: 23'h600});
      step();
      p1.memreq = 0; mem.memready = 0;
      mem.memack = 1; mem.memrdata = 32'hF000_0000;
      aq.push_back('{port: 1'b1, data: 32'hF000_0000});
      step();
      mem.memack = 0; rst = 0;
      step();
      rst = 1;
      @(negedge clk);
      chk("t6_tags_dropped", {31'd0, dut.tag_empty}, 32'd1);
      step();
      mem.memack = 1;
      step();
      mem.memack = 0;
      @(negedge clk);
      chk("t6_err", {31'd0, err}, 32'd1);
      step();

      // pointer back at port 0 after reset
      p0.memaddr = 23'h700; p0.memlen = 2'd0; p0.memreq = 1;
      p1.memaddr = 23'h710; p1.memlen = 2'd0; p1.memreq = 1;
      mem.memready = 1;
      gq.push_back('{port: post_rst_port, addr: post_rst_port ? 23'h710 : 23'h700});
      step();
      p0.memreq = 0; p1.memreq = 0; mem.memready = 0;
      step();

      chk("grants_drained", gq.size(), 32'd0);
      chk("acks_drained", aq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
